// File: rtl/adc_fill_reader.sv
// Consumer of ADC acquisition FIFO fill records: checks sequence/checksum, forwards data bursts.
// Define ADC_FILL_READER_CHECKSUM_EN to build the XOR checksum accumulator and compare.
module adc_fill_reader #(
  parameter int unsigned BURST_CNT_W    = 23,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_enable,
  input  logic [127:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] fill_hdr,
  output logic [127:0] wfm_hdr,
  output logic [23:0]  fill_cnt,
  output logic         fill_done,
  output logic         checksum_err,
  output logic         seq_err,
  output logic         timeout_err,
  output logic         sm_idle
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StFillHdr,
    StWfmHdr,
    StData,
    StChecksum,
    StDone
  } state_e;

  state_e                 state_q;
  logic [BURST_CNT_W-1:0] burst_q;
  logic [TmoW-1:0]        tmo_q;
  logic                   accept;
  logic                   tmo_active;
  logic                   tmo_hit;

  // Depends only on state and the output register, never on in_valid.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StFillHdr, StWfmHdr, StChecksum: in_ready = 1'b1;
      StData:                          in_ready = !out_valid || out_ready;
      default:                         in_ready = 1'b0;
    endcase
  end

  assign accept     = in_valid && in_ready;
  assign tmo_active = (state_q == StWfmHdr) || (state_q == StData) || (state_q == StChecksum);
  // Fires on the edge where the idle count would reach TIMEOUT_CYCLES.
  assign tmo_hit    = tmo_active && !in_valid && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      burst_q     <= '0;
      tmo_q       <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      fill_hdr    <= '0;
      wfm_hdr     <= '0;
      fill_cnt    <= '0;
      fill_done   <= 1'b0;
      seq_err     <= 1'b0;
      timeout_err <= 1'b0;
      sm_idle     <= 1'b1;
    end else begin
      fill_done   <= 1'b0;
      seq_err     <= 1'b0;
      timeout_err <= 1'b0;

      if ((state_q == StData) && accept) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Backpressure stalls keep in_valid high, so they never advance the count.
      if (!tmo_active || accept) begin
        tmo_q <= '0;
      end else if (!in_valid) begin
        tmo_q <= tmo_q + 1'b1;
      end

      if (tmo_hit) begin
        timeout_err <= 1'b1;
        state_q     <= StIdle;
        sm_idle     <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rd_enable) begin
              state_q <= StFillHdr;
              sm_idle <= 1'b0;
            end
          end
          StFillHdr: begin
            if (accept) begin
              fill_hdr <= in_data;
              seq_err  <= (in_data[23:0] != fill_cnt);
              state_q  <= StWfmHdr;
            end
          end
          StWfmHdr: begin
            if (accept) begin
              wfm_hdr <= in_data;
              burst_q <= in_data[BURST_CNT_W-1:0];
              state_q <= (in_data[BURST_CNT_W-1:0] == '0) ? StChecksum : StData;
            end
          end
          StData: begin
            if (accept) begin
              burst_q <= burst_q - 1'b1;
              if (burst_q == BURST_CNT_W'(1)) begin
                state_q <= StChecksum;
              end
            end
          end
          StChecksum: begin
            if (accept) begin
              fill_done <= 1'b1;
              state_q   <= StDone;
            end
          end
          StDone: begin
            // Resync to the received header so one bad number costs one seq_err only.
            fill_cnt <= fill_hdr[23:0] + 24'd1;
            state_q  <= StIdle;
            sm_idle  <= 1'b1;
          end
          default: begin
            state_q <= StIdle;
            sm_idle <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef ADC_FILL_READER_CHECKSUM_EN
  logic [127:0] acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q        <= '0;
      checksum_err <= 1'b0;
    end else begin
      checksum_err <= 1'b0;
      if ((state_q == StData) && accept) begin
        acc_q <= acc_q ^ in_data;
      end else if ((state_q == StDone) || tmo_hit) begin
        acc_q <= '0;
      end
      if ((state_q == StChecksum) && accept) begin
        checksum_err <= (in_data != acc_q);
      end
    end
  end
`else
  assign checksum_err = 1'b0;
`endif

endmodule
